// File: rtl/sdf_commutator.sv
// Radix-2 single-path delay-feedback stage controller: pairs each sample with the one DEPTH samples
// earlier for external butterflies and re-times the results. Define SDF_SCALE_EN to halve butterfly results.
module sdf_commutator #(
    parameter int unsigned IL    = 16,
    parameter int unsigned OL    = IL + 1,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 4,
    localparam int unsigned IW   = (CW > 1) ? CW - 1 : 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iVALID,
    input  logic          iSOF,
    input  logic [IL-1:0] iDATA_RE,
    input  logic [IL-1:0] iDATA_IM,
    output logic [IL-1:0] oBF_A_RE,
    output logic [IL-1:0] oBF_A_IM,
    output logic [IL-1:0] oBF_B_RE,
    output logic [IL-1:0] oBF_B_IM,
    input  logic [OL-1:0] iBF_ADD_RE,
    input  logic [OL-1:0] iBF_ADD_IM,
    input  logic [OL-1:0] iBF_SUB_RE,
    input  logic [OL-1:0] iBF_SUB_IM,
    output logic          oVALID,
    output logic          oSOF,
    output logic          oPHASE,
    output logic [IW-1:0] oIDX,
    output logic [OL-1:0] oDATA_RE,
    output logic [OL-1:0] oDATA_IM
);

    localparam int unsigned OW1 = OL + 1;

    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    logic          primed_q, primed_d, primed_eff;
    logic          phase;
    logic [IW-1:0] idx;
    logic [OL-1:0] dl_re_q [DEPTH];
    logic [OL-1:0] dl_im_q [DEPTH];
    logic [OL-1:0] head_re, head_im, push_re, push_im;
    logic          valid_q, valid_d, sof_q, sof_d, phase_q, phase_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [OL-1:0] re_q, re_d, im_q, im_d;

    // Optional halving of butterfly results with round-half-up
    function automatic logic [OL-1:0] scale_f(input logic [OL-1:0] x);
`ifdef SDF_SCALE_EN
        logic [OL:0] t;
        t = {x[OL-1], x} + OW1'(1);
        return t[OL:1];
`else
        return x;
`endif
    endfunction

    // A start-of-frame sample is position 0; restarting mid-frame drops stale feedback
    always_comb begin
        cnt_eff    = iSOF ? '0 : cnt_q;
        primed_eff = primed_q & ~(iSOF & (cnt_q != '0));
    end

    assign phase = cnt_eff[CW-1];

    generate
        if (CW > 1) begin : g_idx
            assign idx = cnt_eff[IW-1:0];
        end else begin : g_noidx
            assign idx = 1'b0;
        end
    endgenerate

    assign head_re  = dl_re_q[DEPTH-1];
    assign head_im  = dl_im_q[DEPTH-1];
    assign oBF_A_RE = head_re[IL-1:0];
    assign oBF_A_IM = head_im[IL-1:0];
    assign oBF_B_RE = iDATA_RE;
    assign oBF_B_IM = iDATA_IM;

    always_comb begin
        push_re = phase ? scale_f(iBF_SUB_RE) : {{(OL-IL){iDATA_RE[IL-1]}}, iDATA_RE};
        push_im = phase ? scale_f(iBF_SUB_IM) : {{(OL-IL){iDATA_IM[IL-1]}}, iDATA_IM};
    end

    always_comb begin
        cnt_d    = cnt_q;
        primed_d = primed_q;
        valid_d  = 1'b0;
        sof_d    = 1'b0;
        phase_d  = phase_q;
        idx_d    = idx_q;
        re_d     = re_q;
        im_d     = im_q;
        if (iVALID) begin
            cnt_d    = CW'(cnt_eff + CW'(1));
            primed_d = primed_eff | (cnt_eff == CW'(2 * DEPTH - 1));
            if (phase | primed_eff) begin
                valid_d = 1'b1;
                sof_d   = (cnt_eff == CW'(DEPTH));
                phase_d = phase;
                idx_d   = idx;
                re_d    = phase ? scale_f(iBF_ADD_RE) : head_re;
                im_d    = phase ? scale_f(iBF_ADD_IM) : head_im;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            phase_q  <= 1'b0;
            idx_q    <= '0;
            re_q     <= '0;
            im_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
            sof_q    <= sof_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            re_q     <= re_d;
            im_q     <= im_d;
        end
    end

    // Feedback line keeps its contents through reset; primed gates its use
    always_ff @(posedge iCLK) begin
        if (iVALID) begin
            dl_re_q[0] <= push_re;
            dl_im_q[0] <= push_im;
            for (int i = 1; i < DEPTH; i++) begin
                dl_re_q[i] <= dl_re_q[i-1];
                dl_im_q[i] <= dl_im_q[i-1];
            end
        end
    end

    assign oVALID   = valid_q;
    assign oSOF     = sof_q;
    assign oPHASE   = phase_q;
    assign oIDX     = idx_q;
    assign oDATA_RE = re_q;
    assign oDATA_IM = im_q;

endmodule

// File: tb/tb_sdf_commutator.sv
// Scoreboard bench for sdf_commutator: frame-level reference model, directed and random stimulus.
// Honours SDF_SCALE_EN in the reference model when the design is built with it.
module tb_sdf_commutator;

    localparam int unsigned IL = 16;
    localparam int unsigned OL = 17;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = 4;

    typedef struct {
        int re;
        int im;
        bit ph;
        int idx;
        bit sof;
    } exp_t;

    logic          clk = 1'b0;
    logic          iRST = 1'b0, iVALID = 1'b0, iSOF = 1'b0;
    logic [IL-1:0] iDATA_RE = '0, iDATA_IM = '0;
    logic [IL-1:0] oBF_A_RE, oBF_A_IM, oBF_B_RE, oBF_B_IM;
    logic [OL-1:0] bf_add_re, bf_add_im, bf_sub_re, bf_sub_im;
    logic          oVALID, oSOF, oPHASE;
    logic [2:0]    oIDX;
    logic [OL-1:0] oDATA_RE, oDATA_IM;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   obs_re[$], obs_im[$], saved_re[$], saved_im[$];
    bit   exp_v_in = 1'b0, exp_v_q = 1'b0, mon_en = 1'b0;

    int m_pos = 0;
    bit m_primed = 1'b0;
    int f_re[D], f_im[D], pd_re[D], pd_im[D];

    always #5 clk = ~clk;

    // External butterflies
    assign bf_add_re = {oBF_A_RE[IL-1], oBF_A_RE} + {oBF_B_RE[IL-1], oBF_B_RE};
    assign bf_add_im = {oBF_A_IM[IL-1], oBF_A_IM} + {oBF_B_IM[IL-1], oBF_B_IM};
    assign bf_sub_re = {oBF_A_RE[IL-1], oBF_A_RE} - {oBF_B_RE[IL-1], oBF_B_RE};
    assign bf_sub_im = {oBF_A_IM[IL-1], oBF_A_IM} - {oBF_B_IM[IL-1], oBF_B_IM};

    sdf_commutator #(.IL(IL), .OL(OL), .DEPTH(D), .CW(CW)) dut (
        .iCLK(clk), .iRST(iRST), .iVALID(iVALID), .iSOF(iSOF),
        .iDATA_RE(iDATA_RE), .iDATA_IM(iDATA_IM),
        .oBF_A_RE(oBF_A_RE), .oBF_A_IM(oBF_A_IM), .oBF_B_RE(oBF_B_RE), .oBF_B_IM(oBF_B_IM),
        .iBF_ADD_RE(bf_add_re), .iBF_ADD_IM(bf_add_im),
        .iBF_SUB_RE(bf_sub_re), .iBF_SUB_IM(bf_sub_im),
        .oVALID(oVALID), .oSOF(oSOF), .oPHASE(oPHASE), .oIDX(oIDX),
        .oDATA_RE(oDATA_RE), .oDATA_IM(oDATA_IM)
    );

    // Expected output-valid, one cycle behind the accepted sample
    always @(posedge clk) exp_v_q <= iRST ? 1'b0 : exp_v_in;

    function automatic int scl(input int v);
`ifdef SDF_SCALE_EN
        return (v + 1) >>> 1;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, expv, $time);
        end
    endtask

    task automatic chk_obs(input string name, input int q[$], input int i, input int expv);
        if (q.size() > i) chk(name, q[i], expv);
        else chk({name, "_missing"}, q.size(), i + 1);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (oVALID !== exp_v_q || (oVALID !== 1'b1 && oSOF !== 1'b0)) begin
                    failures++;
                    $display("FAIL valid_timing got v=%b sof=%b exp v=%b t=%0t", oVALID, oSOF, exp_v_q, $time);
                end
                if (oVALID === 1'b1) begin
                    obs_re.push_back(int'($signed(oDATA_RE)));
                    obs_im.push_back(int'($signed(oDATA_IM)));
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_output re=%0d t=%0t", $signed(oDATA_RE), $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'($signed(oDATA_RE)) != e.re || int'($signed(oDATA_IM)) != e.im ||
                            oPHASE !== e.ph || int'(oIDX) != e.idx || oSOF !== e.sof) begin
                            failures++;
                            $display("FAIL output got re=%0d im=%0d ph=%b idx=%0d sof=%b exp re=%0d im=%0d ph=%b idx=%0d sof=%b t=%0t",
                                     $signed(oDATA_RE), $signed(oDATA_IM), oPHASE, oIDX, oSOF,
                                     e.re, e.im, e.ph, e.idx, e.sof, $time);
                        end
                    end
                end
            end
        end
    endtask

    // One clock of stimulus; the reference model works on frame positions and stored half-frames
    task automatic drive(input bit v, input bit s, input int re, input int im);
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        iVALID = v; iSOF = s;
        iDATA_RE = IL'(re); iDATA_IM = IL'(im);
        exp_v_in = 1'b0;
        if (v) begin
            if (s) begin
                if (m_pos != 0) m_primed = 1'b0;
                m_pos = 0;
            end
            if (m_pos < D) begin
                if (m_primed) begin
                    e = '{pd_re[m_pos], pd_im[m_pos], 1'b0, m_pos, 1'b0};
                    exp_q.push_back(e);
                    exp_v_in = 1'b1;
                end
                f_re[m_pos] = re;
                f_im[m_pos] = im;
            end else begin
                k = m_pos - D;
                e = '{scl(f_re[k] + re), scl(f_im[k] + im), 1'b1, k, k == 0};
                pd_re[k] = scl(f_re[k] - re);
                pd_im[k] = scl(f_im[k] - im);
                exp_q.push_back(e);
                exp_v_in = 1'b1;
            end
            m_pos++;
            if (m_pos == 2 * D) begin
                m_pos = 0;
                m_primed = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'(($urandom_range(0, 1))), int'($urandom_range(0, 65535)) - 32768, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        iRST = 1'b1; iVALID = 1'b0; iSOF = 1'b0; exp_v_in = 1'b0;
        m_pos = 0; m_primed = 1'b0;
        @(posedge clk);
        #1;
        iRST = 1'b0;
        @(negedge clk);
        chk("reset_outputs", int'({oVALID, oSOF, oPHASE, oIDX}) + int'(oDATA_RE != '0) + int'(oDATA_IM != '0), 0);
    endtask

    // Two ramp frames (RE = n), optionally with an idle cycle after every sample
    task automatic ramp(input bit toggle);
        for (int f = 0; f < 2; f++)
            for (int n = 0; n < 16; n++) begin
                drive(1'b1, n == 0, n, 0);
                if (toggle) idle(1);
            end
        idle(2);
    endtask

    task automatic cmp_saved(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < saved_re.size(); i++)
            if (i >= obs_re.size() || obs_re[i] != saved_re[i] || obs_im[i] != saved_im[i]) bad++;
        chk({name, "_len"}, obs_re.size(), saved_re.size());
        chk({name, "_diffs"}, bad, 0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        do_reset();
        mon_en = 1'b1;

        // Contiguous ramp after reset
        obs_re.delete(); obs_im.delete();
        ramp(1'b0);
        chk("ramp_count", obs_re.size(), 24);
        chk_obs("ramp_first_sum", obs_re, 0, scl(8));
        chk_obs("ramp_last_sum", obs_re, 7, scl(22));
        chk_obs("ramp_fill_diff0", obs_re, 8, scl(-8));
        chk_obs("ramp_fill_diff7", obs_re, 15, scl(-8));
        saved_re = obs_re; saved_im = obs_im;

        // Same ramp with gapped valid must give the same sequence
        do_reset();
        obs_re.delete(); obs_im.delete();
        ramp(1'b1);
        cmp_saved("toggle");

        // Frame restart at position 5
        for (int n = 0; n < 5; n++) drive(1'b1, n == 0, n * 3, -n);
        idle(2);
        obs_re.delete(); obs_im.delete();
        for (int n = 0; n < 8; n++) drive(1'b1, n == 0, 100 + n, n);
        idle(2);
        chk("restart_fill_silent", obs_re.size(), 0);
        for (int n = 8; n < 16; n++) drive(1'b1, 1'b0, 100 + n, n);
        idle(2);
        chk("restart_phase1_count", obs_re.size(), 8);

        // Reset at position 11, then behave as after reset
        for (int n = 0; n < 11; n++) drive(1'b1, n == 0, n, n);
        do_reset();
        obs_re.delete(); obs_im.delete();
        ramp(1'b0);
        cmp_saved("after_reset");

        // Extreme operands on the imaginary path
        obs_re.delete(); obs_im.delete();
        for (int n = 0; n < 16; n++) drive(1'b1, n == 0, 0, (n == 0) ? -32768 : ((n == 8) ? 32767 : 0));
        for (int n = 0; n < 16; n++) drive(1'b1, n == 0, 0, 0);
        idle(2);
        chk_obs("extreme_sum", obs_im, 8, scl(-1));
        chk_obs("extreme_diff", obs_im, 16, scl(-65535));

        // Random traffic with gaps, restarts and occasional reset
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0),
                       int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        end
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
